// File: rtl/uart_rx_fifo_if.sv
// Bus between rx_core / Avalon read path and the UART receive FIFO.
// The FIFO is the slave; the byte source and the pop logic together form the master.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              rd_en;
  logic              ovr_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              rx_irq;
  logic              overrun;

  modport master (
    output rx_data, rx_done, rd_en, ovr_clr,
    input  rd_data, rd_valid, empty, full, count, rx_irq, overrun
  );

  modport slave (
    input  rx_data, rx_done, rd_en, ovr_clr,
    output rd_data, rd_valid, empty, full, count, rx_irq, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures a byte on each rising edge of rx_done, pops on rd_en.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads instead of a registered pop.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int IRQ_LEVEL = 8
) (
  input  logic           rx_clk,
  input  logic           reset_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IrqCnt   = (ADDR_W + 1)'(IRQ_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rxDone_q;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              irq_q, irq_d;
  logic              overrun_q, overrun_d;

  logic push;
  logic popAcc;
  logic pushAcc;
  logic drop;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  always_comb begin
    push    = bus.rx_done & ~rxDone_q;
    popAcc  = bus.rd_en & ~empty_q;
    pushAcc = push & (~full_q | popAcc);
    drop    = push & full_q & ~popAcc;
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (pushAcc) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popAcc) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end

    unique case ({pushAcc, popAcc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DepthCnt);
    irq_d   = (count_d >= IrqCnt);
  end

  // rxDone_q resets high so a strobe already asserted at reset release is not a push.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxDone_q  <= 1'b1;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rxDone_q  <= bus.rx_done;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (pushAcc) begin
      mem[wrPtr_q] <= bus.rx_data;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Head entry is shown directly; forced to zero when nothing is stored.
  assign bus.rd_data  = empty_q ? '0 : mem[rdPtr_q];
  assign bus.rd_valid = ~empty_q;
`else
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;

  always_comb begin
    rdData_d  = rdData_q;
    rdValid_d = popAcc;
    if (popAcc) begin
      rdData_d = mem[rdPtr_q];
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign bus.rd_data  = rdData_q;
  assign bus.rd_valid = rdValid_q;
`endif

  assign bus.count   = count_q;
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.rx_irq  = irq_q;
  assign bus.overrun = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of rx_core in the UART slave. It captures each byte that rx_core presents on rx_data, at the rising edge of rx_done, into a circular FIFO. It holds the bytes until the Avalon-side register logic pops them. It also reports fill level, a threshold interrupt and a sticky overrun flag.

Parameters:
DATA_W, 8, width of each received byte and of rd_data
ADDR_W, 4, log2 of FIFO depth (DEPTH = 2**ADDR_W = 16 entries)
IRQ_LEVEL, 8, rx_irq asserts when count >= IRQ_LEVEL; legal range 1..DEPTH

Ports:
rx_clk  input  1  single clock for the whole block, rising edge
reset_n  input  1  asynchronous, active-low reset
rx_data  input  DATA_W  byte from rx_core; valid when rx_done rises
rx_done  input  1  completion strobe from rx_core; level signal, only its rising edge counts
rd_en  input  1  pop request from the Avalon read path
rd_data  output  DATA_W  popped byte
rd_valid  output  1  rd_data holds a newly popped byte (see Behaviour)
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
rx_irq  output  1  count >= IRQ_LEVEL
overrun  output  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - empty = 1, full = 0, rx_irq = 0, overrun = 0
  - rd_data = 0, rd_valid = 0
  - rx_done_q = 1, so an rx_done already high at reset release does not cause a push
  - Stored contents are discarded. Reset mid-byte or mid-pop leaves no partial state.
- Push detect: push = rx_done & ~rx_done_q; rx_done_q registers rx_done every cycle. There is one push per rising edge, however long rx_done stays high.
- Push:
  - Not full, or full with a pop accepted in the same cycle: mem[wr_ptr] <= rx_data, and wr_ptr increments.
  - Full with no pop in the same cycle: byte dropped, overrun <= 1, pointers and count unchanged.
- Pop: accepted only when rd_en = 1 and empty = 0, then rd_ptr increments. rd_en while empty is ignored: no pointer change, rd_valid = 0, rd_data holds.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0 naturally. count is a separate ADDR_W+1 counter:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop or on neither
- Simultaneous events:
  - Push and pop when empty: pop ignored, push accepted, count goes 0 -> 1.
  - Push and pop when full: both accepted, count stays DEPTH, no overrun.
  - ovr_clr and a dropped push in the same cycle: set wins, overrun = 1.
- empty, full and rx_irq are registered and derived from the next value of count. They are therefore correct in the same cycle that count updates.
- Read latency (default build): rd_data <= mem[rd_ptr] and rd_valid <= 1 on the rx_clk edge following an accepted pop. rd_valid is a one-cycle pulse, and rd_data holds until the next pop.
- Ordering: strict FIFO. The byte order at rd_data equals the order of rx_done rising edges.

Optional Feature:
Macro UART_RX_FIFO_FWFT_EN (first-word fall-through):
- Defined:
  - rd_data continuously shows the head entry mem[rd_ptr], and rd_valid = ~empty (level, not pulse).
  - rd_en acknowledges and removes the head, and the next entry appears the cycle after.
  - A byte pushed into an empty FIFO appears on rd_data with rd_valid = 1 one cycle after the push edge.
  - Push and pop when empty: pop ignored as in the default build.
- Undefined: the registered one-cycle-latency pop described above.
- Port list, count, flags and overrun behaviour are identical in both builds.

Test Plan:
1. Reset then idle -> empty = 1, full = 0, count = 0, rd_data = 0, overrun = 0. rx_done held high through reset release produces no push.
2. Three rx_done edges with rx_data 0x41, 0x42, 0x43, then three rd_en pulses -> rd_data 0x41, 0x42, 0x43 in order, each with rd_valid one cycle after its rd_en; count goes 3 -> 0, then empty = 1.
3. rx_done held high for 5 cycles with rx_data = 0x55 -> exactly one push, count = 1.
4. 17 pushes of 0x00..0x10 with no pops -> full = 1 after the 16th push; the 17th push (0x10) is dropped and overrun = 1. Popping 16 returns 0x00..0x0F, which exercises pointer wrap. ovr_clr then gives overrun = 0.
5. FIFO full, with push (0xAA) and rd_en in the same cycle -> count stays 16, overrun stays 0, and 0xAA is the last byte popped. FIFO empty, with push and rd_en in the same cycle -> count = 1, rd_valid = 0.
6. IRQ_LEVEL = 8: pushes 1..8 give rx_irq = 1 in the same cycle count reaches 8; one pop gives rx_irq = 0. Rerun scenarios 2 and 5 with UART_RX_FIFO_FWFT_EN defined: rd_data = 0x41 and rd_valid = 1 before any rd_en.
